// File: rtl/element_stream_out.sv
// Snapshots eight 32-bit result words on start and streams them little-endian as bytes over valid/ready.
// Define STREAM_HDR_EN to prefix each frame with a 5-byte header (HDR_BYTE + stall/flush count snapshot).
module element_stream_out #(
  parameter int          CNT_W    = 16,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      element1,
  input  logic [31:0]      element2,
  input  logic [31:0]      element3,
  input  logic [31:0]      element4,
  input  logic [31:0]      element5,
  input  logic [31:0]      element6,
  input  logic [31:0]      element7,
  input  logic [31:0]      element8,
  input  logic             stall,
  input  logic             flush,
  input  logic             start,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

`ifdef STREAM_HDR_EN
  localparam int HDR_N = 5;
`else
  localparam int HDR_N = 0;
`endif
  localparam int         FRAME_N  = 32 + HDR_N;
  localparam logic [5:0] LAST_IDX = 6'(FRAME_N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state, state_nxt;
  logic [255:0] payload;
  logic [5:0]   idx;
  logic         load, xfer;
  logic [4:0]   pidx;
  logic [7:0]   byte_sel;

  // Handshake: a byte moves on a rising edge where tx_valid and tx_ready are both 1.
  // tx_valid stays high for the whole frame; tx_data/tx_last only change after a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          xfer = 1'b1;
          if (idx == LAST_IDX) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      payload <= '0;
      idx     <= '0;
    end else if (load) begin
      payload <= {element8, element7, element6, element5,
                  element4, element3, element2, element1};
      idx     <= '0;
    end else if (xfer) begin
      idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
    end
  end

`ifdef STREAM_HDR_EN
  logic [15:0] stall16, flush16, hdr_stall, hdr_flush;

  // Header carries exactly 16 bits per counter: truncated if wider, zero-filled if narrower.
  assign stall16 = 16'(stall_count);
  assign flush16 = 16'(flush_count);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_stall <= '0;
      hdr_flush <= '0;
    end else if (load) begin
      hdr_stall <= stall16;
      hdr_flush <= flush16;
    end
  end

  always_comb begin
    pidx = 5'(idx - 6'd5);
    case (idx)
      6'd0:    byte_sel = HDR_BYTE;
      6'd1:    byte_sel = hdr_stall[7:0];
      6'd2:    byte_sel = hdr_stall[15:8];
      6'd3:    byte_sel = hdr_flush[7:0];
      6'd4:    byte_sel = hdr_flush[15:8];
      default: byte_sel = payload[{pidx, 3'b000} +: 8];
    endcase
  end
`else
  always_comb begin
    pidx     = idx[4:0];
    byte_sel = payload[{pidx, 3'b000} +: 8];
  end
`endif

  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);
  assign tx_last  = (state == SEND) && (idx == LAST_IDX);
  assign tx_data  = (state == SEND) ? byte_sel : 8'h00;

  // Performance counters run in every state and saturate instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
      if (flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_element_stream_out.sv
// Directed bench for element_stream_out: framing, backpressure, snapshot, counters, async reset.
`timescale 1ns/1ps
module tb_element_stream_out;

`ifdef STREAM_HDR_EN
  localparam int HDR_N  = 5;
  localparam int BP_CYC = 73;
`else
  localparam int HDR_N  = 0;
  localparam int BP_CYC = 64;
`endif
  localparam int FRAME_N = 32 + HDR_N;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] el [8];
  logic        stall = 1'b0, flush = 1'b0, start = 1'b0, tx_ready = 1'b0;
  logic        stall4 = 1'b0, zero = 1'b0;
  logic        tx_valid, tx_last, busy;
  logic [7:0]  tx_data;
  logic [15:0] stall_count, flush_count;
  logic        tx_valid4, tx_last4, busy4;
  logic [7:0]  tx_data4;
  logic [3:0]  stall_count4, flush_count4;

  element_stream_out dut (
    .clk(clk), .reset(reset),
    .element1(el[0]), .element2(el[1]), .element3(el[2]), .element4(el[3]),
    .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
    .stall(stall), .flush(flush), .start(start), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .busy(busy),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  element_stream_out #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset),
    .element1(el[0]), .element2(el[1]), .element3(el[2]), .element4(el[3]),
    .element5(el[4]), .element6(el[5]), .element7(el[6]), .element8(el[7]),
    .stall(stall4), .flush(zero), .start(zero), .tx_ready(zero),
    .tx_valid(tx_valid4), .tx_data(tx_data4), .tx_last(tx_last4), .busy(busy4),
    .stall_count(stall_count4), .flush_count(flush_count4)
  );

  // scoreboard state
  int          checks = 0, passed = 0, fails = 0;
  int          exp_stall = 0, exp_flush = 0;
  int          ncyc;
  logic [31:0] snap [8];
`ifdef STREAM_HDR_EN
  logic [15:0] hs, hf;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int          p;
    logic [31:0] w;
`ifdef STREAM_HDR_EN
    case (k)
      0: return 8'hA5;
      1: return hs[7:0];
      2: return hs[15:8];
      3: return hf[7:0];
      4: return hf[15:8];
      default: ;
    endcase
`endif
    p = k - HDR_N;
    w = snap[p / 4];
    return w[8 * (p % 4) +: 8];
  endfunction

  // driver tasks
  task automatic tick();
    if (stall && exp_stall < 65535) exp_stall++;
    if (flush && exp_flush < 65535) exp_flush++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    for (int i = 0; i < 8; i++) snap[i] = el[i];
`ifdef STREAM_HDR_EN
    hs = exp_stall[15:0];
    hf = exp_flush[15:0];
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stream(input bit bp, input bit glitch, output int cyc);
    int k;
    k   = 0;
    cyc = 0;
    while (k < FRAME_N && cyc < 300) begin
      chk("valid", {31'd0, tx_valid}, 32'd1);
      chk("busy", {31'd0, busy}, 32'd1);
      chk($sformatf("byte%0d", k), {24'd0, tx_data}, {24'd0, exp_byte(k)});
      chk($sformatf("last%0d", k), {31'd0, tx_last}, (k == FRAME_N - 1) ? 32'd1 : 32'd0);
      if (glitch) begin
        if (k == HDR_N + 5) for (int i = 0; i < 8; i++) el[i] = 32'hFFFF_FFFF;
        start = (k == HDR_N + 10) || (k == FRAME_N - 1);
      end
      tx_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      tick();
      cyc++;
      if (tx_ready) k++;
    end
    tx_ready = 1'b0;
    start    = 1'b0;
    chk("frame_done", k, FRAME_N);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("valid_end", {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) el[i] = 32'd0;
    #12;
    // reset state
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_last", {31'd0, tx_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {16'd0, stall_count}, 32'd0);
    chk("rst_flush", {16'd0, flush_count}, 32'd0);
    chk("rst4_valid", {31'd0, tx_valid4}, 32'd0);
    chk("rst4_data", {24'd0, tx_data4}, 32'd0);
    chk("rst4_last", {31'd0, tx_last4}, 32'd0);
    chk("rst4_busy", {31'd0, busy4}, 32'd0);
    chk("rst4_flush", {28'd0, flush_count4}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // tx_ready is ignored while idle
    tx_ready = 1'b1;
    tick(); tick();
    chk("idle_valid", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // basic frame, ready held high
    for (int i = 0; i < 8; i++) el[i] = 32'(i + 1);
    start_frame();
    chk("b0_hand", {24'd0, tx_data}, (HDR_N == 0) ? 32'h01 : 32'hA5);
    stream(1'b0, 1'b0, ncyc);
    chk("cycles_full", ncyc, FRAME_N);

    // back-to-back start with 1,0,0,1 backpressure
    start_frame();
    stream(1'b1, 1'b0, ncyc);
    chk("cycles_bp", ncyc, BP_CYC);

    // snapshot holds through input change; mid-frame and last-cycle starts ignored
    el[0] = 32'hDEADBEEF; el[1] = 32'h01234567; el[2] = 32'h89ABCDEF; el[3] = 32'h00FF00FF;
    el[4] = 32'hCAFEF00D; el[5] = 32'h5A5A5A5A; el[6] = 32'h12345678; el[7] = 32'h80000001;
    start_frame();
    chk("b0_snap", {24'd0, tx_data}, (HDR_N == 0) ? 32'hEF : 32'hA5);
    stream(1'b0, 1'b1, ncyc);
    repeat (3) begin
      tick();
      chk("no_extra", {31'd0, tx_valid}, 32'd0);
    end

    // counters: stall 10 cycles, flush 3 cycles, two overlapping
    for (int c = 0; c < 11; c++) begin
      stall = (c < 10);
      flush = (c >= 8);
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    chk("stall_cnt", {16'd0, stall_count}, 32'd10);
    chk("flush_cnt", {16'd0, flush_count}, 32'd3);

    // narrow counter saturates
    stall4 = 1'b1;
    repeat (20) tick();
    stall4 = 1'b0;
    chk("stall4_sat", {28'd0, stall_count4}, 32'd15);

    // async reset at byte 12
    start_frame();
    tx_ready = 1'b1;
    repeat (12 + HDR_N) tick();
    tx_ready = 1'b0;
    chk("pre_rst_byte", {24'd0, tx_data}, {24'd0, exp_byte(12 + HDR_N)});
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, tx_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_data", {24'd0, tx_data}, 32'd0);
    chk("arst_last", {31'd0, tx_last}, 32'd0);
    chk("arst_stall", {16'd0, stall_count}, 32'd0);
    chk("arst_flush", {16'd0, flush_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    tick();
    chk("post_rst_idle", {31'd0, tx_valid}, 32'd0);
    start_frame();
    stream(1'b0, 1'b0, ncyc);

`ifdef STREAM_HDR_EN
    // header: stall_count 0x0102, flush_count 0x0003
    for (int c = 0; c < 258; c++) begin
      stall = 1'b1;
      flush = (c < 3);
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    chk("hdr_stall_cnt", {16'd0, stall_count}, 32'h0102);
    chk("hdr_flush_cnt", {16'd0, flush_count}, 32'h0003);
    start_frame();
    chk("hdr_b0", {24'd0, tx_data}, 32'hA5);
    stream(1'b0, 1'b0, ncyc);
`endif

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
